cdc_wr_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares the write port of one 8-bit CDC FIFO between N requesters.
//  All requesters live in the FIFO write-clock domain.

---
 rtl/cdc_wr_arbiter_pkg.sv | 23 ++
 rtl/cdc_wr_arbiter_rr_pick.sv | 30 +++
 rtl/cdc_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_cdc_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_wr_arbiter_pkg.sv
// Shared types and constants for the CDC FIFO write-port arbiter.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Upper nibble of every source-tag header byte.
  localparam logic [3:0] HDR_MARK = 4'hA;

  // Ceiling log2, minimum result 0; used only on elaboration constants.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning ptr+1, ptr+2, ... mod N.
module rr_pick
  import cdc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] id,
  output logic          any
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    id  = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        id  = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_wr_arbiter.sv
// Packet-level round-robin arbiter feeding the write side of an 8-bit CDC FIFO.
// Each granted packet is optionally prefixed by a {HDR_MARK, id} tag byte.
module cdc_wr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int MAXLEN = 256,
  parameter int TAG_EN = 1,
  localparam int IW    = clog2(N),
  localparam int LW    = clog2(MAXLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_vd,
  input  logic [N*DW-1:0] req_dat,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_rdy,
  input  logic            fifo_afull,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_wr_dat,
  output logic            busy,
  output logic [IW-1:0]   cur_id,
  output logic            pkt_err
);

  state_e          state_q, state_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic            wr_en_q, wr_en_d;
  logic [DW-1:0]   wr_dat_q, wr_dat_d;
  logic            pkt_err_q, pkt_err_d;

  logic [IW-1:0]   pick_id;
  logic            pick_any;
  logic [DW-1:0]   beat_dat;
  logic            beat_last;
  logic            xfer;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req_vd),
    .ptr (ptr_q),
    .id  (pick_id),
    .any (pick_any)
  );

  assign beat_dat  = req_dat[int'(cur_id_q)*DW +: DW];
  assign beat_last = req_last[cur_id_q];
  assign xfer      = (state_q == DATA) && req_vd[cur_id_q] && !fifo_afull;

  // Ready only for the granted requester while data may flow.
  for (genvar g = 0; g < N; g++) begin : g_rdy
    assign req_rdy[g] = (state_q == DATA) && (cur_id_q == IW'(g)) && !fifo_afull;
  end

  assign fifo_wr_en  = wr_en_q;
  assign fifo_wr_dat = wr_dat_q;
  assign busy        = (state_q != IDLE);
  assign cur_id      = cur_id_q;
  assign pkt_err     = pkt_err_q;

  // Next-state and write-stage logic; writes land one clock after acceptance.
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_dat_d  = wr_dat_q;
    pkt_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          cur_id_d = pick_id;
          len_d    = '0;
          state_d  = (TAG_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (!fifo_afull) begin
          wr_en_d  = 1'b1;
          wr_dat_d = {HDR_MARK, (DW-4)'(cur_id_q)};
          state_d  = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wr_en_d  = 1'b1;
          wr_dat_d = beat_dat;
          len_d    = len_q + 1'b1;
          if (beat_last || (len_q == LW'(MAXLEN-1))) begin
            // Forced end flags an error only when the source did not close it.
            pkt_err_d = !beat_last;
            len_d     = '0;
            ptr_d     = cur_id_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; ptr resets to N-1 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_id_q  <= '0;
      ptr_q     <= IW'(N-1);
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_dat_q  <= '0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_dat_q  <= wr_dat_d;
      pkt_err_q <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Bench for cdc_wr_arbiter: u0 (tagged, MAXLEN=4) and u1 (untagged) share one
// stimulus driver; sel chooses which instance is live and observed.
module tb_cdc_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    vd, last;
  logic [N*DW-1:0] dat;
  logic            afull, sel;

  logic [N-1:0] vd0, vd1, rdy0, rdy1;
  logic         wr0, wr1, busy0, busy1, err0, err1;
  logic [DW-1:0] wd0, wd1;
  logic [1:0]   cid0, cid1;

  logic [N-1:0] m_rdy;
  logic         m_wr, m_busy, m_err;
  logic [DW-1:0] m_dat;
  logic [1:0]   m_cid;

  assign vd0    = sel ? '0 : vd;
  assign vd1    = sel ? vd : '0;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_wr   = sel ? wr1   : wr0;
  assign m_dat  = sel ? wd1   : wd0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_cid  = sel ? cid1  : cid0;
  assign m_err  = sel ? err1  : err0;

  cdc_wr_arbiter #(.N(N), .DW(DW), .MAXLEN(4), .TAG_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_vd(vd0), .req_dat(dat), .req_last(last),
    .req_rdy(rdy0), .fifo_afull(afull), .fifo_wr_en(wr0), .fifo_wr_dat(wd0),
    .busy(busy0), .cur_id(cid0), .pkt_err(err0)
  );

  cdc_wr_arbiter #(.N(N), .DW(DW), .MAXLEN(256), .TAG_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_vd(vd1), .req_dat(dat), .req_last(last),
    .req_rdy(rdy1), .fifo_afull(afull), .fifo_wr_en(wr1), .fifo_wr_dat(wd1),
    .busy(busy1), .cur_id(cid1), .pkt_err(err1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] srcq [N][$];  // {last, byte} per requester
  logic [8:0] expq [$];     // {pkt_err, byte} expected FIFO writes
  int         wcyc [$];     // cycle stamps of observed writes

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Requester model: present head of queue, pop when a beat was accepted.
  initial begin
    logic [N-1:0] fire;
    vd = '0; last = '0; dat = '0;
    forever begin
      @(negedge clk);
      fire = vd & m_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          vd[i] = 1'b1;
          dat[i*DW +: DW] = srcq[i][0][7:0];
          last[i] = srcq[i][0][8];
        end else begin
          vd[i] = 1'b0;
          last[i] = 1'b0;
        end
      end
    end
  end

  // FIFO-side scoreboard.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_wr) begin
        wcyc.push_back(cyc);
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_write actual=%0h expected=none", m_dat);
        end else begin
          e = expq.pop_front();
          chk("fifo_write", 32'({m_err, m_dat}), 32'(e));
        end
      end else if (m_err) begin
        checks++; failures++;
        $display("FAIL err_without_write actual=1 expected=0");
      end
    end
  end

  task automatic push_src(input int r, input logic [7:0] b, input logic l);
    srcq[r].push_back({l, b});
  endtask

  task automatic push_exp(input logic [7:0] b, input logic e);
    expq.push_back({e, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(name, 32'(expq.size()), 32'd0);
  endtask

  task automatic wait_wr(input string name, input logic [7:0] b, input int budget);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      hit = m_wr && (m_dat == b);
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  typedef struct {
    logic       afull;
    logic       wr;
    logic [7:0] dat;
    logic       busy;
    logic [3:0] rdy;
    logic [1:0] cid;
  } vec_t;

  vec_t tab [7];

  initial begin
    tab[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd0};
    tab[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b0000, 2'd1};
    tab[2] = '{1'b0, 1'b1, 8'hA1, 1'b1, 4'b0010, 2'd1};
    tab[3] = '{1'b0, 1'b1, 8'h11, 1'b1, 4'b0010, 2'd1};
    tab[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 4'b0010, 2'd1};
    tab[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 4'b0000, 2'd1};
    tab[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd1};

    sel = 1'b0; afull = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({m_wr, m_dat, m_rdy, m_busy, m_cid, m_err}), 32'd0);
    rst_n = 1'b1;

    // Single packet from requester 1, cycle by cycle.
    @(negedge clk);
    push_src(1, 8'h11, 1'b0); push_src(1, 8'h22, 1'b0); push_src(1, 8'h33, 1'b1);
    push_exp(8'hA1, 1'b0); push_exp(8'h11, 1'b0); push_exp(8'h22, 1'b0); push_exp(8'h33, 1'b0);
    @(posedge clk); #1;
    for (int r = 0; r < 7; r++) begin
      afull = tab[r].afull;
      @(negedge clk);
      chk($sformatf("t1_wr_en[%0d]", r), 32'(m_wr), 32'(tab[r].wr));
      if (tab[r].wr) chk($sformatf("t1_wr_dat[%0d]", r), 32'(m_dat), 32'(tab[r].dat));
      chk($sformatf("t1_busy[%0d]", r), 32'(m_busy), 32'(tab[r].busy));
      chk($sformatf("t1_rdy[%0d]", r), 32'(m_rdy), 32'(tab[r].rdy));
      chk($sformatf("t1_cur_id[%0d]", r), 32'(m_cid), 32'(tab[r].cid));
      @(posedge clk); #1;
    end
    drain("t1_drain", 20);

    // Round robin over all four requesters, requester 0 twice.
    do_reset();
    wcyc.delete();
    for (int i = 0; i < N; i++) begin
      push_src(i, 8'(16*i), 1'b0); push_src(i, 8'(16*i+1), 1'b1);
    end
    push_src(0, 8'h02, 1'b0); push_src(0, 8'h03, 1'b1);
    for (int i = 0; i < N; i++) begin
      push_exp(8'(8'hA0 + i), 1'b0); push_exp(8'(16*i), 1'b0); push_exp(8'(16*i+1), 1'b0);
    end
    push_exp(8'hA0, 1'b0); push_exp(8'h02, 1'b0); push_exp(8'h03, 1'b0);
    drain("t2_drain", 100);
    chk("t2_write_count", 32'(wcyc.size()), 32'd15);
    if (wcyc.size() == 15) begin
      for (int k = 0; k < 14; k++)
        chk($sformatf("t2_gap[%0d]", k), 32'(wcyc[k+1] - wcyc[k]), (k % 3 == 2) ? 32'd2 : 32'd1);
    end

    // FIFO almost-full stall for five clocks mid-packet.
    do_reset();
    push_src(2, 8'hC1, 1'b0); push_src(2, 8'hC2, 1'b0); push_src(2, 8'hC3, 1'b1);
    push_exp(8'hA2, 1'b0); push_exp(8'hC1, 1'b0); push_exp(8'hC2, 1'b0); push_exp(8'hC3, 1'b0);
    wait_wr("t3_wait_c1", 8'hC1, 30);
    @(posedge clk); #1;
    afull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t3_rdy_stall[%0d]", k), 32'(m_rdy), 32'd0);
      if (k > 0) chk($sformatf("t3_wr_stall[%0d]", k), 32'(m_wr), 32'd0);
    end
    @(posedge clk); #1;
    afull = 1'b0;
    drain("t3_drain", 30);

    // MAXLEN forced termination and fresh header for the remainder.
    do_reset();
    for (int b = 0; b < 6; b++) push_src(0, 8'(8'hB0 + b), (b == 5));
    push_exp(8'hA0, 1'b0);
    for (int b = 0; b < 4; b++) push_exp(8'(8'hB0 + b), (b == 3));
    push_exp(8'hA0, 1'b0); push_exp(8'hB4, 1'b0); push_exp(8'hB5, 1'b0);
    drain("t4_drain", 60);

    // Asynchronous reset mid-DATA, then requester 0 must win over 2.
    do_reset();
    push_src(1, 8'hD1, 1'b0); push_src(1, 8'hD2, 1'b0); push_src(1, 8'hD3, 1'b1);
    push_exp(8'hA1, 1'b0); push_exp(8'hD1, 1'b0); push_exp(8'hD2, 1'b0); push_exp(8'hD3, 1'b0);
    wait_wr("t5_wait_d1", 8'hD1, 30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", 32'({m_wr, m_dat, m_rdy, m_busy, m_cid, m_err}), 32'd0);
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_src(0, 8'hE0, 1'b1); push_src(2, 8'hE2, 1'b1);
    push_exp(8'hA0, 1'b0); push_exp(8'hE0, 1'b0); push_exp(8'hA2, 1'b0); push_exp(8'hE2, 1'b0);
    drain("t5_drain", 40);

    // Untagged instance: 1-byte packets from requesters 0 and 3 alternate.
    do_reset();
    sel = 1'b1;
    wcyc.delete();
    for (int p = 0; p < 3; p++) begin
      push_src(0, 8'(8'h60 + p), 1'b1); push_src(3, 8'(8'h70 + p), 1'b1);
      push_exp(8'(8'h60 + p), 1'b0); push_exp(8'(8'h70 + p), 1'b0);
    end
    drain("t6_drain", 60);
    chk("t6_write_count", 32'(wcyc.size()), 32'd6);
    if (wcyc.size() == 6) begin
      for (int k = 0; k < 5; k++)
        chk($sformatf("t6_gap[%0d]", k), 32'(wcyc[k+1] - wcyc[k]), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
